wave_monitor: RTL

- Receive-side companion to the function generator: samples the 10-bit DAC data stream on each data_clk rising edge and measures the waveform.
- Reports period (in samples), per-period max/min and peak-to-peak amplitude, lock status and loss-of-signal.
- Sits on the same clk_50MHz domain. data_clk is slow (divided) and is treated as a strobe, synchronized and edge-detected internally.

---
 rtl/wave_monitor.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wave_monitor.sv
// wave_monitor
// Receive-side companion to the function generator. Samples the DAC data
// stream on every rising edge of data_clk and measures the waveform: the
// period in samples, the per-period maximum/minimum, peak-to-peak amplitude,
// lock status and a sticky loss-of-signal flag.
//
// data_clk is slow relative to clk_50MHz, so it is treated as a strobe. It is
// synchronised through two flops and edge-detected with one history flop.
//
// Ports:
//   clk_50MHz    in   system clock
//   rst          in   asynchronous active-high reset
//   data_clk     in   generator sample clock (sample on its rising edge)
//   data_in      in   generator level, DATA_W bits
//   data_in_en   in   generator output enable, 0 = no signal
//   period       out  samples in the last completed period
//   peak_max     out  maximum sample of the last period
//   peak_min     out  minimum sample of the last period
//   p2p          out  peak_max - peak_min
//   result_valid out  one-cycle pulse when period/peaks update
//   locked       out  at least one full period measured since SEEK
//   timeout_flag out  sticky loss-of-signal indicator
//
// Build option: define WAVE_MON_HYST_EN to use hysteresis crossing detection
// (arm below MID-HYST, fire at or above MID+HYST). Without it a crossing is a
// plain upward pass through MID and HYST is unused.

module wave_monitor #(
  parameter int DATA_W  = 10,
  parameter int CNT_W   = 16,
  parameter int MID     = 512,
  parameter int HYST    = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              data_clk,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_en,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic [DATA_W-1:0] p2p,
  output logic              result_valid,
  output logic              locked,
  output logic              timeout_flag
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  // Strobe generation: two synchroniser flops plus one history flop, giving
  // a single-cycle pulse per data_clk rising edge.
  logic syncA_q;
  logic syncB_q;
  logic hist_q;
  logic strobe;

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      syncA_q <= 1'b0;
      syncB_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      syncA_q <= data_clk;
      syncB_q <= syncA_q;
      hist_q  <= syncB_q;
    end
  end

  assign strobe = syncB_q & ~hist_q;

  logic state_is_idle;
  logic clearDetect;
  logic crossing;

  // Crossing history is discarded whenever the monitor is (or is about to be)
  // idle, so the first strobe afterwards can never produce a crossing.
  assign clearDetect = ~data_in_en | state_is_idle;

`ifdef WAVE_MON_HYST_EN
  localparam logic [DATA_W-1:0] LowLvl  = DATA_W'(MID - HYST);
  localparam logic [DATA_W-1:0] HighLvl = DATA_W'(MID + HYST);

  logic armed_q;
  logic armed_d;

  assign crossing = strobe & armed_q & (data_in >= HighLvl);

  // The armed flag is set by any sample below the lower threshold and is
  // consumed by the crossing, so noise inside the band cannot fire.
  always_comb begin
    armed_d = armed_q;
    if (clearDetect) begin
      armed_d = 1'b0;
    end else if (strobe) begin
      if (data_in < LowLvl) begin
        armed_d = 1'b1;
      end else if (crossing) begin
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end
`else
  localparam logic [DATA_W-1:0] MidLvl = DATA_W'(MID);

  logic              prevValid_q;
  logic              prevValid_d;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] prev_d;
  logic              unusedHyst;

  assign unusedHyst = ^(DATA_W'(HYST));

  assign crossing = strobe & prevValid_q & (prev_q < MidLvl) & (data_in >= MidLvl);

  // The previous sample follows every strobe; it only becomes valid once a
  // strobe has been seen outside IDLE.
  always_comb begin
    prevValid_d = prevValid_q;
    prev_d      = prev_q;
    if (clearDetect) begin
      prevValid_d = 1'b0;
    end else if (strobe) begin
      prevValid_d = 1'b1;
      prev_d      = data_in;
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      prevValid_q <= 1'b0;
      prev_q      <= '0;
    end else begin
      prevValid_q <= prevValid_d;
      prev_q      <= prev_d;
    end
  end
`endif

  // Measurement state
  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [DATA_W-1:0] runMax_q,  runMax_d;
  logic [DATA_W-1:0] runMin_q,  runMin_d;
  logic [CNT_W-1:0]  period_q,  period_d;
  logic [DATA_W-1:0] peakMax_q, peakMax_d;
  logic [DATA_W-1:0] peakMin_q, peakMin_d;
  logic [DATA_W-1:0] p2p_q,     p2p_d;
  logic              valid_q,   valid_d;
  logic              locked_q,  locked_d;
  logic              timeout_q, timeout_d;

  logic [CNT_W-1:0]  cntInc;
  logic              hitTimeout;

  assign state_is_idle = (state_q == IDLE);

  // Counter saturates at TIMEOUT; reaching it is the loss-of-signal event.
  assign cntInc     = (cnt_q == TimeoutCnt) ? cnt_q : cnt_q + CNT_W'(1);
  assign hitTimeout = (cntInc == TimeoutCnt);

  // Next-state logic. A low enable overrides everything, including a
  // crossing on the same cycle. A crossing beats a simultaneous timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    runMax_d  = runMax_q;
    runMin_d  = runMin_q;
    period_d  = period_q;
    peakMax_d = peakMax_q;
    peakMin_d = peakMin_q;
    p2p_d     = p2p_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (!data_in_en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d    = '0;
          locked_d = 1'b0;
          state_d  = SEEK;
        end
        SEEK: begin
          if (strobe) begin
            if (crossing) begin
              cnt_d    = CNT_W'(1);
              runMax_d = data_in;
              runMin_d = data_in;
              state_d  = MEASURE;
            end else if (hitTimeout) begin
              timeout_d = 1'b1;
              cnt_d     = '0;
            end else begin
              cnt_d = cntInc;
            end
          end
        end
        MEASURE: begin
          if (strobe) begin
            if (crossing) begin
              // The closing crossing sample belongs to the next period.
              period_d  = cnt_q;
              peakMax_d = runMax_q;
              peakMin_d = runMin_q;
              p2p_d     = runMax_q - runMin_q;
              valid_d   = 1'b1;
              locked_d  = 1'b1;
              timeout_d = 1'b0;
              cnt_d     = CNT_W'(1);
              runMax_d  = data_in;
              runMin_d  = data_in;
            end else if (hitTimeout) begin
              locked_d  = 1'b0;
              timeout_d = 1'b1;
              cnt_d     = '0;
              state_d   = SEEK;
            end else begin
              cnt_d    = cntInc;
              runMax_d = (data_in > runMax_q) ? data_in : runMax_q;
              runMin_d = (data_in < runMin_q) ? data_in : runMin_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      runMax_q  <= '0;
      runMin_q  <= '1;
      period_q  <= '0;
      peakMax_q <= '0;
      peakMin_q <= '0;
      p2p_q     <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      runMax_q  <= runMax_d;
      runMin_q  <= runMin_d;
      period_q  <= period_d;
      peakMax_q <= peakMax_d;
      peakMin_q <= peakMin_d;
      p2p_q     <= p2p_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign peak_max     = peakMax_q;
  assign peak_min     = peakMin_q;
  assign p2p          = p2p_q;
  assign result_valid = valid_q;
  assign locked       = locked_q;
  assign timeout_flag = timeout_q;

endmodule
